// File: rtl/athena_dip_bank.sv
// athena_dip_bank: bank of NUM_REGS bus-writable settings registers with staged, atomic commit.
// Host writes land in shadow registers; the live settings change only when a commit is pending
// and the core reports a safe point, so every register updates on the same clock edge.
// Optional build macro ATHENA_DIP_BANK_AUTO_COMMIT_EN: any in-range shadow write also requests a commit.
// Ports:
//   clk_i              bridge clock, posedge
//   reset_n_i          asynchronous active-low reset
//   addr_i             word address (0..NUM_REGS-1 shadow, NUM_REGS CTRL/STATUS, above unmapped)
//   wr_i / wr_data_i   single-cycle write strobe and data
//   rd_i               single-cycle read strobe
//   rd_data_o          registered read data, valid the cycle after rd_i
//   rd_data_valid_o    one-cycle pulse the cycle after rd_i
//   apply_ok_i         core safe point (level)
//   settings_o         committed register values, reg 0 in the LSBs
//   settings_changed_o one-cycle pulse after settings_o is updated
//   commit_pending_o   high while a commit waits for apply_ok_i
module athena_dip_bank #(
   parameter int NUM_REGS = 4,
   parameter int REG_WIDTH = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter logic [NUM_REGS*REG_WIDTH-1:0] DEFAULTS = '0
) (
   input  logic                          clk_i,
   input  logic                          reset_n_i,
   input  logic [ADDR_WIDTH-1:0]         addr_i,
   input  logic                          wr_i,
   input  logic [DATA_WIDTH-1:0]         wr_data_i,
   input  logic                          rd_i,
   output logic [DATA_WIDTH-1:0]         rd_data_o,
   output logic                          rd_data_valid_o,
   input  logic                          apply_ok_i,
   output logic [NUM_REGS*REG_WIDTH-1:0] settings_o,
   output logic                          settings_changed_o,
   output logic                          commit_pending_o
);
   localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   typedef enum logic {IDLE, PENDING} state_e;
   state_e state_q, state_d;
   logic [REG_WIDTH-1:0] shadow_q [NUM_REGS];
   logic [REG_WIDTH-1:0] shadow_d [NUM_REGS];
   logic [REG_WIDTH-1:0] active_q [NUM_REGS];
   logic [REG_WIDTH-1:0] active_d [NUM_REGS];
   logic [7:0] count_q, count_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic rd_valid_q, changed_q, changed_d, pending_q;
   logic shadow_hit, ctrl_hit, shadow_wr, commit_w, cancel_w, auto_w, wr_data_unused;
   logic [IW-1:0] idx;
   assign idx = addr_i[IW-1:0];
   assign shadow_hit = addr_i < ADDR_WIDTH'(NUM_REGS);
   assign ctrl_hit = addr_i == ADDR_WIDTH'(NUM_REGS);
   assign shadow_wr = wr_i && shadow_hit;
   assign commit_w = wr_i && ctrl_hit && wr_data_i[0];
   assign cancel_w = wr_i && ctrl_hit && wr_data_i[1];
   // Only the low REG_WIDTH and CTRL bits of the write data are meaningful.
   assign wr_data_unused = ^wr_data_i;
`ifdef ATHENA_DIP_BANK_AUTO_COMMIT_EN
   assign auto_w = shadow_wr;
`else
   assign auto_w = 1'b0;
`endif
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      state_d = state_q;
      count_d = count_q;
      changed_d = 1'b0;
      if (cancel_w) begin
         shadow_d = active_q;
         state_d = IDLE;
      end else if (state_q == PENDING && apply_ok_i) begin
         // Apply takes the pre-write shadow; an auto-commit write in the same cycle re-arms.
         active_d = shadow_q;
         count_d = count_q + 8'd1;
         changed_d = 1'b1;
         state_d = auto_w ? PENDING : IDLE;
      end else if (commit_w || auto_w) begin
         state_d = PENDING;
      end
      if (shadow_wr) shadow_d[idx] = wr_data_i[REG_WIDTH-1:0];
      rd_data_d = shadow_hit ? DATA_WIDTH'(shadow_q[idx]) :
                  ctrl_hit ? DATA_WIDTH'({count_q, 7'b0, pending_q}) : '0;
   end
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            shadow_q[i] <= DEFAULTS[i*REG_WIDTH +: REG_WIDTH];
            active_q[i] <= DEFAULTS[i*REG_WIDTH +: REG_WIDTH];
         end
         state_q <= IDLE;
         count_q <= '0;
         rd_data_q <= '0;
         rd_valid_q <= 1'b0;
         changed_q <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         state_q <= state_d;
         count_q <= count_d;
         rd_valid_q <= rd_i;
         changed_q <= changed_d;
         pending_q <= state_d == PENDING;
         if (rd_i) rd_data_q <= rd_data_d;
      end
   end
   for (genvar g = 0; g < NUM_REGS; g++) begin : g_settings
      assign settings_o[g*REG_WIDTH +: REG_WIDTH] = active_q[g];
   end
   assign rd_data_o = rd_data_q;
   assign rd_data_valid_o = rd_valid_q;
   assign settings_changed_o = changed_q;
   assign commit_pending_o = pending_q;
endmodule

// File: tb/tb_athena_dip_bank.sv
// tb_athena_dip_bank: directed self-checking bench for athena_dip_bank.
module tb_athena_dip_bank;
   localparam logic [63:0] DEF = 64'h0004_0003_0002_0001;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic [7:0] addr = '0;
   logic wr = 1'b0;
   logic [31:0] wr_data = '0;
   logic rd = 1'b0;
   logic [31:0] rd_data;
   logic rd_data_valid;
   logic apply_ok = 1'b0;
   logic [63:0] settings;
   logic settings_changed;
   logic commit_pending;
   int vectors = 0;
   int miscompares = 0;

   athena_dip_bank #(.DEFAULTS(DEF)) dut (
      .clk_i(clk), .reset_n_i(reset_n), .addr_i(addr), .wr_i(wr), .wr_data_i(wr_data),
      .rd_i(rd), .rd_data_o(rd_data), .rd_data_valid_o(rd_data_valid), .apply_ok_i(apply_ok),
      .settings_o(settings), .settings_changed_o(settings_changed), .commit_pending_o(commit_pending)
   );

   always #5 clk = ~clk;

   task automatic do_write(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      addr = a; wr_data = d; wr = 1'b1;
      @(negedge clk);
      wr = 1'b0;
   endtask

   task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic v);
      @(negedge clk);
      addr = a; rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      d = rd_data; v = rd_data_valid;
   endtask

   task automatic test_reset;
      logic [31:0] d;
      logic v;
      repeat (2) @(negedge clk);
      vectors++;
      if (settings !== DEF) begin miscompares++; $display("FAIL reset_settings got %h want %h", settings, DEF); end
      vectors++;
      if ({rd_data, rd_data_valid, settings_changed, commit_pending} !== 35'd0) begin
         miscompares++; $display("FAIL reset_outputs got %h/%b/%b/%b want 0", rd_data, rd_data_valid, settings_changed, commit_pending);
      end
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         do_read(8'(i), d, v);
         vectors++;
         if (d !== 32'(i + 1) || v !== 1'b1) begin
            miscompares++; $display("FAIL reset_read%0d got %h/%b want %h/1", i, d, v, i + 1);
         end
      end
      @(negedge clk);
      vectors++;
      if (rd_data_valid !== 1'b0) begin miscompares++; $display("FAIL valid_single_cycle got %b want 0", rd_data_valid); end
      do_read(8'd4, d, v);
      vectors++;
      if (d !== 32'h0 || v !== 1'b1) begin miscompares++; $display("FAIL reset_status got %h/%b want 0/1", d, v); end
   endtask

   task automatic test_commit;
      logic [31:0] d;
      logic v;
      do_write(8'd1, 32'hABCD_1234);
      vectors++;
      if (settings !== DEF) begin miscompares++; $display("FAIL nocommit_settings got %h want %h", settings, DEF); end
      do_read(8'd1, d, v);
      vectors++;
      if (d !== 32'h0000_1234) begin miscompares++; $display("FAIL shadow_read got %h want 00001234", d); end
      do_write(8'd4, 32'h1);
      for (int i = 0; i < 10; i++) begin
         vectors++;
         if (commit_pending !== 1'b1 || settings !== DEF || settings_changed !== 1'b0) begin
            miscompares++; $display("FAIL pending_wait%0d got %b/%h/%b want 1/%h/0", i, commit_pending, settings, settings_changed, DEF);
         end
         @(negedge clk);
      end
      apply_ok = 1'b1;
      @(negedge clk);
      apply_ok = 1'b0;
      vectors++;
      if (settings !== 64'h0004_0003_1234_0001 || settings_changed !== 1'b1 || commit_pending !== 1'b0) begin
         miscompares++; $display("FAIL apply got %h/%b/%b want 0004000312340001/1/0", settings, settings_changed, commit_pending);
      end
      @(negedge clk);
      vectors++;
      if (settings_changed !== 1'b0) begin miscompares++; $display("FAIL changed_pulse got %b want 0", settings_changed); end
      do_read(8'd4, d, v);
      vectors++;
      if (d !== 32'h0000_0100) begin miscompares++; $display("FAIL status_count1 got %h want 00000100", d); end
   endtask

   task automatic test_cancel;
      logic [31:0] d;
      logic v;
      do_write(8'd2, 32'h5555);
      do_write(8'd4, 32'h1);
      do_write(8'd4, 32'h2);
      vectors++;
      if (commit_pending !== 1'b0 || settings !== 64'h0004_0003_1234_0001) begin
         miscompares++; $display("FAIL cancel got %b/%h want 0/0004000312340001", commit_pending, settings);
      end
      do_read(8'd2, d, v);
      vectors++;
      if (d !== 32'h3) begin miscompares++; $display("FAIL cancel_revert got %h want 3", d); end
      do_write(8'd0, 32'h0BAD);
      do_write(8'd4, 32'h1);
      do_write(8'd4, 32'h3);
      apply_ok = 1'b1;
      @(negedge clk);
      apply_ok = 1'b0;
      vectors++;
      if (commit_pending !== 1'b0 || settings_changed !== 1'b0 || settings !== 64'h0004_0003_1234_0001) begin
         miscompares++; $display("FAIL cancel_wins got %b/%b/%h want 0/0/0004000312340001", commit_pending, settings_changed, settings);
      end
      do_read(8'd0, d, v);
      vectors++;
      if (d !== 32'h1) begin miscompares++; $display("FAIL cancel_wins_revert got %h want 1", d); end
   endtask

   task automatic test_unmapped;
      logic [31:0] d;
      logic v;
      do_write(8'd5, 32'hFFFF);
      do_read(8'd5, d, v);
      vectors++;
      if (d !== 32'h0 || v !== 1'b1) begin miscompares++; $display("FAIL unmapped_read got %h/%b want 0/1", d, v); end
      do_read(8'd4, d, v);
      vectors++;
      if (d !== 32'h0000_0100 || settings !== 64'h0004_0003_1234_0001) begin
         miscompares++; $display("FAIL unmapped_nochange got %h/%h want 00000100/0004000312340001", d, settings);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] d;
      logic v;
      @(negedge clk);
      addr = 8'd3; wr_data = 32'h7777; wr = 1'b1; rd = 1'b1;
      @(negedge clk);
      wr = 1'b0; rd = 1'b0;
      vectors++;
      if (rd_data !== 32'h4 || rd_data_valid !== 1'b1) begin
         miscompares++; $display("FAIL rw_collision got %h/%b want 4/1", rd_data, rd_data_valid);
      end
      do_read(8'd3, d, v);
      vectors++;
      if (d !== 32'h7777) begin miscompares++; $display("FAIL rw_collision_after got %h want 7777", d); end
      do_write(8'd0, 32'h0011);
      do_write(8'd4, 32'h1);
      @(negedge clk);
      addr = 8'd0; wr_data = 32'h0022; wr = 1'b1; apply_ok = 1'b1;
      @(negedge clk);
      wr = 1'b0; apply_ok = 1'b0;
      vectors++;
      if (settings !== 64'h7777_0003_1234_0011 || commit_pending !== 1'b0 || settings_changed !== 1'b1) begin
         miscompares++; $display("FAIL apply_with_write got %h/%b/%b want 7777000312340011/0/1", settings, commit_pending, settings_changed);
      end
      do_read(8'd0, d, v);
      vectors++;
      if (d !== 32'h0022) begin miscompares++; $display("FAIL apply_with_write_shadow got %h want 22", d); end
   endtask

   task automatic test_wrap;
      logic [31:0] d;
      logic v;
      apply_ok = 1'b1;
      for (int i = 0; i < 253; i++) begin
         do_write(8'd4, 32'h1);
         @(negedge clk);
      end
      apply_ok = 1'b0;
      do_read(8'd4, d, v);
      vectors++;
      if (d !== 32'h0000_FF00) begin miscompares++; $display("FAIL status_count255 got %h want 0000ff00", d); end
      apply_ok = 1'b1;
      do_write(8'd4, 32'h1);
      @(negedge clk);
      apply_ok = 1'b0;
      vectors++;
      if (settings_changed !== 1'b1 || settings !== 64'h7777_0003_1234_0022) begin
         miscompares++; $display("FAIL same_value_commit got %b/%h want 1/7777000312340022", settings_changed, settings);
      end
      do_read(8'd4, d, v);
      vectors++;
      if (d !== 32'h0) begin miscompares++; $display("FAIL status_wrap got %h want 0", d); end
   endtask

   task automatic test_reset_pending;
      logic [31:0] d;
      logic v;
      do_write(8'd1, 32'h00EE);
      do_write(8'd4, 32'h1);
      reset_n = 1'b0;
      #1;
      vectors++;
      if (settings !== DEF || commit_pending !== 1'b0) begin
         miscompares++; $display("FAIL reset_pending got %h/%b want %h/0", settings, commit_pending, DEF);
      end
      @(negedge clk);
      reset_n = 1'b1;
      apply_ok = 1'b1;
      @(negedge clk);
      @(negedge clk);
      apply_ok = 1'b0;
      vectors++;
      if (settings !== DEF || settings_changed !== 1'b0) begin
         miscompares++; $display("FAIL reset_discard got %h/%b want %h/0", settings, settings_changed, DEF);
      end
      do_read(8'd1, d, v);
      vectors++;
      if (d !== 32'h2) begin miscompares++; $display("FAIL reset_shadow got %h want 2", d); end
   endtask

   task automatic test_auto_commit;
      apply_ok = 1'b1;
      @(negedge clk);
      addr = 8'd0; wr_data = 32'h00AA; wr = 1'b1;
      @(negedge clk);
      wr = 1'b0;
      vectors++;
      if (commit_pending !== 1'b1 || settings !== DEF) begin
         miscompares++; $display("FAIL auto_pending got %b/%h want 1/%h", commit_pending, settings, DEF);
      end
      @(negedge clk);
      apply_ok = 1'b0;
      vectors++;
      if (settings !== 64'h0004_0003_0002_00AA || settings_changed !== 1'b1) begin
         miscompares++; $display("FAIL auto_apply got %h/%b want 00040003000200aa/1", settings, settings_changed);
      end
   endtask

   initial begin
      test_reset;
`ifdef ATHENA_DIP_BANK_AUTO_COMMIT_EN
      test_auto_commit;
`else
      test_commit;
      test_cancel;
      test_unmapped;
      test_back_to_back;
      test_wrap;
      test_reset_pending;
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/athena_dip_bank.md
Name: athena_dip_bank

Overview:
Parametrised successor to the single DIP-switch register: a bank of NUM_REGS configuration registers on the bridge bus with staged/atomic commit. Host writes land in shadow registers. The live `settings` outputs change only when a commit is requested and the core signals a safe point (`apply_ok`), so all registers update on the same clock edge. Sits between the bridge decoder and the core's DIP/option inputs.

Parameters:
NUM_REGS, 4, number of setting registers (1..64)
REG_WIDTH, 16, bits per register (1..32)
ADDR_WIDTH, 8, bus word-address width; must satisfy 2**ADDR_WIDTH > NUM_REGS
DATA_WIDTH, 32, bridge data width (>= REG_WIDTH, >= 16)
DEFAULTS, '0, NUM_REGS*REG_WIDTH flat reset value; reg i = DEFAULTS[i*REG_WIDTH +: REG_WIDTH]

Ports:
clk  in  1  bridge clock; all logic on posedge
reset_n  in  1  asynchronous active-low reset
addr  in  ADDR_WIDTH  word address, valid with wr/rd
wr  in  1  write strobe, single cycle
wr_data  in  DATA_WIDTH  write data
rd  in  1  read strobe, single cycle
rd_data  out  DATA_WIDTH  read data, registered
rd_data_valid  out  1  high exactly one cycle after rd
apply_ok  in  1  core safe point (e.g. vblank/halted); level
settings  out  NUM_REGS*REG_WIDTH  live (committed) register values
settings_changed  out  1  one-cycle pulse the cycle after settings update
commit_pending  out  1  high while a commit waits for apply_ok

Behaviour:
- Reset (async assert, sync release): shadow[i] and active[i] = DEFAULTS slice; state IDLE; commit_count = 0; rd_data = 0; rd_data_valid = 0; settings_changed = 0; commit_pending = 0.
- Address map:
  - 0..NUM_REGS-1: shadow reg.
  - NUM_REGS: CTRL/STATUS.
  - Above NUM_REGS: unmapped. Writes are ignored; reads return 0 with a valid pulse.
- Shadow write: shadow[addr] <= wr_data[REG_WIDTH-1:0]; upper bits dropped. Shadow read: zero-extended shadow[addr].
- CTRL write:
  - bit0 = COMMIT, bit1 = CANCEL.
  - If both are set, CANCEL wins.
  - Other bits ignored.
- STATUS read:
  - bit0 = commit_pending.
  - bits[15:8] = commit_count (8-bit, wraps 255->0).
  - Other bits 0.
- Read latency: rd_data/rd_data_valid update on the edge after rd. A simultaneous wr and rd to the same shadow address returns the old value.
- `settings` = concatenation of active[]; reg 0 in LSBs. Driven directly from flops.
- FSM:
  - IDLE: COMMIT write -> PENDING. apply_ok is not sampled in that cycle, so the minimum commit latency is 1 cycle after entry.
  - PENDING, CANCEL write -> IDLE; shadow[i] <= active[i] for all i.
  - PENDING, apply_ok=1 (and no CANCEL) -> IDLE; active[i] <= shadow[i] for all i; commit_count++; settings_changed=1 next cycle.
  - PENDING, COMMIT write again: no effect (coalesced).
  - PENDING, shadow write: allowed. If apply fires the same edge, the apply takes the pre-write shadow value, the write still lands in shadow, and the FSM ends in IDLE.
  - IDLE, CANCEL: shadow reverts to active; FSM stays IDLE.
- commit_pending = (state == PENDING), registered.
- settings_changed pulses even if the committed values equal the previous ones.
- Reset mid-PENDING: commit is discarded; all values return to DEFAULTS.

Optional Feature:
- Macro ATHENA_DIP_BANK_AUTO_COMMIT_EN.
- Defined: any in-range shadow write also acts as a COMMIT, putting the FSM in or keeping it in PENDING. This gives DIP-switch-like "write takes effect at next safe point" behaviour without a CTRL write. The CTRL COMMIT bit is still honoured.
- Undefined: shadow writes never change FSM state.

Test Plan:
- Reset with DEFAULTS=64'h0004_0003_0002_0001 -> settings=64'h0004_0003_0002_0001, reads of addr 0..3 return 1,2,3,4 one cycle after rd, STATUS=0.
- Write addr1=32'hABCD_1234, no commit -> settings unchanged, read addr1 returns 32'h0000_1234.
- Then write CTRL=1 with apply_ok=0 for 10 cycles, then 1 -> commit_pending=1 for the wait, settings reg1=16'h1234 on the first edge apply_ok is sampled high, settings_changed one-cycle pulse, STATUS[15:8]=1.
- Write addr2=16'h5555, CTRL=1, then CTRL=2 before apply_ok -> FSM IDLE, settings unchanged, read addr2 returns 3 (reverted).
- Write addr5 (unmapped)=16'hFFFF and read addr5 -> no state change, rd_data=0, rd_data_valid pulses.
- 256 commits -> STATUS[15:8] wraps to 0. With AUTO_COMMIT_EN, a single write addr0=16'h00AA with apply_ok=1 -> settings reg0=16'h00AA two cycles later, no CTRL write.
